// File: rtl/canvas_pkg.sv
// Shared definitions for the MNIST drawing canvas: geometry, FSM states
// and the row-major cell index helper.
package canvas_pkg;

    localparam int DIM   = 28;
    localparam int NPIX  = 784;
    localparam int IDX_W = 10;
    localparam int ROW_W = 5;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DIM - 1);

    typedef enum logic [1:0] {
        IDLE,
        PAINT,
        CLEAR,
        STREAM
    } state_t;

    // Flat canvas bit index for row r, column c (row-major, DIM cells per row).
    function automatic logic [IDX_W-1:0] cellIndex(input logic [ROW_W-1:0] r,
                                                   input logic [ROW_W-1:0] c);
        return IDX_W'(r) * IDX_W'(DIM) + IDX_W'(c);
    endfunction

endpackage

// File: rtl/canvas_painter_if.sv
// Bus between the mouse path / NN engine / display and the canvas painter.
// The master drives cursor, commands and stream_ready; the slave (painter)
// drives the stream, status and canvas image.
interface canvas_painter_if;
    logic [9:0]   cursor_x;
    logic [9:0]   cursor_y;
    logic [7:0]   buttons;
    logic         cursor_valid;
    logic         clear;
    logic         stream_start;
    logic         stream_ready;
    logic         stream_valid;
    logic         stream_data;
    logic         stream_last;
    logic         busy;
    logic [783:0] canvas;
    logic [9:0]   pixel_count;

    modport master (
        output cursor_x, cursor_y, buttons, cursor_valid, clear,
               stream_start, stream_ready,
        input  stream_valid, stream_data, stream_last, busy, canvas,
               pixel_count
    );

    modport slave (
        input  cursor_x, cursor_y, buttons, cursor_valid, clear,
               stream_start, stream_ready,
        output stream_valid, stream_data, stream_last, busy, canvas,
               pixel_count
    );
endinterface

// File: rtl/canvas_coord_map.sv
// Maps a cursor screen position to a canvas (row, col) cell and flags
// whether the cursor lies on the canvas. Purely combinational; also used by
// color_mapper for the cursor highlight.
module canvas_coord_map
    import canvas_pkg::*;
#(
    parameter int CELL_SHIFT = 4,
    parameter int ORIGIN_X   = 96,
    parameter int ORIGIN_Y   = 16
)(
    input  logic [9:0]       cursor_x_i,
    input  logic [9:0]       cursor_y_i,
    output logic [ROW_W-1:0] row_o,
    output logic [ROW_W-1:0] col_o,
    output logic             in_range_o
);

    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + (DIM << CELL_SHIFT));
    localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + (DIM << CELL_SHIFT));

    logic       xIn;
    logic       yIn;
    logic [9:0] offX;
    logic [9:0] offY;

    // Range check first; the offset is only formed when in range so it never wraps.
    always_comb begin
        xIn        = ({1'b0, cursor_x_i} >= X_LO) && ({1'b0, cursor_x_i} < X_HI);
        yIn        = ({1'b0, cursor_y_i} >= Y_LO) && ({1'b0, cursor_y_i} < Y_HI);
        offX       = xIn ? (cursor_x_i - 10'(ORIGIN_X)) : 10'd0;
        offY       = yIn ? (cursor_y_i - 10'(ORIGIN_Y)) : 10'd0;
        col_o      = ROW_W'(offX >> CELL_SHIFT);
        row_o      = ROW_W'(offY >> CELL_SHIFT);
        in_range_o = xIn && yIn;
    end

endmodule

// File: rtl/canvas_painter.sv
// 28x28 binary canvas owner: paints/erases a 2x2 brush at the cursor,
// clears row by row, streams pixels serially to the NN and tracks the
// number of set cells.
module canvas_painter
    import canvas_pkg::*;
#(
    parameter int CELL_SHIFT = 4,
    parameter int ORIGIN_X   = 96,
    parameter int ORIGIN_Y   = 16
)(
    input logic             Clk,
    input logic             Reset,
    canvas_painter_if.slave bus
);

    localparam logic [ROW_W:0] DIM_EXT = (ROW_W + 1)'(DIM);

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROW_W-1:0]  col_q, col_d;
    logic              value_q, value_d;
    logic [1:0]        step_q, step_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NPIX-1:0]   canvas_q, canvas_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic              sValid_q, sValid_d;
    logic              sData_q, sData_d;
    logic              sLast_q, sLast_d;

    logic [ROW_W-1:0]  mapRow;
    logic [ROW_W-1:0]  mapCol;
    logic              mapInRange;

    logic [ROW_W:0]    paintRow;
    logic [ROW_W:0]    paintCol;
    logic              paintInBounds;
    logic [IDX_W-1:0]  paintIdx;
    logic [IDX_W-1:0]  idxNext;
    logic              unusedButtons;

    assign unusedButtons = ^bus.buttons[7:2];

    canvas_coord_map #(
        .CELL_SHIFT (CELL_SHIFT),
        .ORIGIN_X   (ORIGIN_X),
        .ORIGIN_Y   (ORIGIN_Y)
    ) u_coord_map (
        .cursor_x_i (bus.cursor_x),
        .cursor_y_i (bus.cursor_y),
        .row_o      (mapRow),
        .col_o      (mapCol),
        .in_range_o (mapInRange)
    );

    // Brush cell for the current PAINT step; cells past the canvas edge are clipped.
    always_comb begin
        paintRow      = {1'b0, row_q} + {{ROW_W{1'b0}}, step_q[1]};
        paintCol      = {1'b0, col_q} + {{ROW_W{1'b0}}, step_q[0]};
        paintInBounds = (paintRow < DIM_EXT) && (paintCol < DIM_EXT);
        paintIdx      = cellIndex(paintRow[ROW_W-1:0], paintCol[ROW_W-1:0]);
        idxNext       = idx_q + 1'b1;
    end

    // Next-state and datapath updates for all four modes.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        value_d  = value_q;
        step_d   = step_q;
        idx_d    = idx_q;
        canvas_d = canvas_q;
        count_d  = count_q;
        sValid_d = sValid_q;
        sData_d  = sData_q;
        sLast_d  = sLast_q;

        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    state_d = CLEAR;
                    row_d   = '0;
                end else if (bus.stream_start) begin
                    state_d  = STREAM;
                    idx_d    = '0;
                    sValid_d = 1'b1;
                    sData_d  = canvas_q[0];
                    sLast_d  = 1'b0;
                end else if (bus.cursor_valid && mapInRange &&
                             (bus.buttons[0] || bus.buttons[1])) begin
                    state_d = PAINT;
                    row_d   = mapRow;
                    col_d   = mapCol;
                    value_d = bus.buttons[0];
                    step_d  = '0;
                end
            end

            PAINT: begin
                if (paintInBounds && (canvas_q[paintIdx] != value_q)) begin
                    canvas_d[paintIdx] = value_q;
                    count_d = value_q ? (count_q + 1'b1) : (count_q - 1'b1);
                end
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = IDLE;
                end
            end

            CLEAR: begin
                canvas_d[cellIndex(row_q, '0) +: DIM] = '0;
                row_d = row_q + 1'b1;
                if (row_q == LAST_ROW) begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end

            STREAM: begin
                if (sValid_q && bus.stream_ready) begin
                    if (idx_q == LAST_IDX) begin
                        sValid_d = 1'b0;
                        sData_d  = 1'b0;
                        sLast_d  = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        idx_d   = idxNext;
                        sData_d = canvas_q[idxNext];
                        sLast_d = (idxNext == LAST_IDX);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; synchronous reset overrides any operation.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            value_q  <= 1'b0;
            step_q   <= '0;
            idx_q    <= '0;
            canvas_q <= '0;
            count_q  <= '0;
            sValid_q <= 1'b0;
            sData_q  <= 1'b0;
            sLast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            value_q  <= value_d;
            step_q   <= step_d;
            idx_q    <= idx_d;
            canvas_q <= canvas_d;
            count_q  <= count_d;
            sValid_q <= sValid_d;
            sData_q  <= sData_d;
            sLast_q  <= sLast_d;
        end
    end

    assign bus.stream_valid = sValid_q;
    assign bus.stream_data  = sData_q;
    assign bus.stream_last  = sLast_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.canvas       = canvas_q;
    assign bus.pixel_count  = count_q;

endmodule
